// File: rtl/pwm_meas_pkg.sv
// Shared types and defaults for the PWM measurement block.
package pwm_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meas_state_t;

    localparam int MEAS_W_DEF   = 16;
    localparam int FILT_LEN_DEF = 3;

endpackage

// File: rtl/pwm_meas_if.sv
// Bus between the PWM measurement block and its user: input waveform, clear and results.
interface pwm_meas_if #(
    parameter int W = pwm_meas_pkg::MEAS_W_DEF
) ();

    logic         pwm_in;
    logic         clr;
    logic [W-1:0] high_time;
    logic [W-1:0] period;
    logic         valid;
    logic         timeout;
    logic         level;

    modport master (
        output pwm_in, clr,
        input  high_time, period, valid, timeout, level
    );

    modport slave (
        input  pwm_in, clr,
        output high_time, period, valid, timeout, level
    );

endinterface

// File: rtl/pwm_sync_edge.sv
// Synchronizes the raw PWM input, optionally glitch-filters it (PWM_MEAS_FILT_EN), and
// produces single-cycle rise/fall strobes plus the settled level.
module pwm_sync_edge
    import pwm_meas_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic rise,
    output logic fall,
    output logic level
);

    if (FILT_LEN < 1) begin : g_bad_filt
        $error("pwm_sync_edge: FILT_LEN must be at least 1");
    end

    logic [1:0] sync;
    logic       s;
    logic       d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], pwm_in};
    end

`ifdef PWM_MEAS_FILT_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] run;
    logic          filt;

    // The filtered level only follows once the raw level has disagreed for FILT_LEN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            run  <= '0;
        end else if (sync[1] == filt) begin
            run <= '0;
        end else if (run == CW'(FILT_LEN - 1)) begin
            filt <= sync[1];
            run  <= '0;
        end else begin
            run <= run + 1'b1;
        end
    end

    assign s = filt;
`else
    assign s = sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d <= 1'b0;
        else        d <= s;
    end

    assign rise  = s & ~d;
    assign fall  = ~s & d;
    assign level = s;

endmodule

// File: rtl/pwm_meas.sv
// Measures high time and period of a PWM input, publishing both once per period.
// Optional glitch filter on the input path is enabled with PWM_MEAS_FILT_EN.
module pwm_meas
    import pwm_meas_pkg::*;
#(
    parameter int W        = MEAS_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_meas_if.slave  bus
);

    if (W < 2) begin : g_bad_w
        $error("pwm_meas: W must be at least 2");
    end

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    logic         rise;
    logic         fall;
    logic         level;

    meas_state_t  state, state_nx;
    logic [W-1:0] cnt_hi, hi_nx;
    logic [W-1:0] cnt_per, per_nx;
    logic [W-1:0] high_time_q, ht_nx;
    logic [W-1:0] period_q, prd_nx;
    logic         valid_q, valid_nx;
    logic         timeout_q, to_nx;

    pwm_sync_edge #(.FILT_LEN(FILT_LEN)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (bus.pwm_in),
        .rise   (rise),
        .fall   (fall),
        .level  (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt_hi      <= '0;
            cnt_per     <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt_hi      <= hi_nx;
            cnt_per     <= per_nx;
            high_time_q <= ht_nx;
            period_q    <= prd_nx;
            valid_q     <= valid_nx;
            timeout_q   <= to_nx;
        end
    end

    // A saturated period counter aborts the measurement before any counter can wrap.
    always_comb begin
        state_nx = state;
        hi_nx    = cnt_hi;
        per_nx   = cnt_per;
        ht_nx    = high_time_q;
        prd_nx   = period_q;
        valid_nx = 1'b0;
        to_nx    = timeout_q;
        if (bus.clr) begin
            state_nx = IDLE;
            hi_nx    = '0;
            per_nx   = '0;
            ht_nx    = '0;
            prd_nx   = '0;
            to_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        hi_nx    = ONE;
                        per_nx   = ONE;
                        state_nx = HIGH;
                    end
                end
                HIGH: begin
                    if (cnt_per == CNT_MAX) begin
                        to_nx    = 1'b1;
                        state_nx = IDLE;
                        hi_nx    = '0;
                        per_nx   = '0;
                    end else begin
                        per_nx = cnt_per + ONE;
                        if (level) hi_nx = cnt_hi + ONE;
                        if (fall)  state_nx = LOW;
                    end
                end
                LOW: begin
                    if (cnt_per == CNT_MAX) begin
                        to_nx    = 1'b1;
                        state_nx = IDLE;
                        hi_nx    = '0;
                        per_nx   = '0;
                    end else if (rise) begin
                        ht_nx    = cnt_hi;
                        prd_nx   = cnt_per;
                        valid_nx = 1'b1;
                        hi_nx    = ONE;
                        per_nx   = ONE;
                        state_nx = HIGH;
                    end else begin
                        per_nx = cnt_per + ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    hi_nx    = '0;
                    per_nx   = '0;
                end
            endcase
        end
    end

    assign bus.high_time = high_time_q;
    assign bus.period    = period_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.level     = level;

endmodule

// File: doc/pwm_meas.md
Name: pwm_meas

Overview:
Downstream companion to the PWM generator. Samples a single PWM waveform, measures its high time and full period in clk cycles, and publishes both with a one-cycle valid strobe once per period. Used to close the loop on generated PWM (self-check) and to capture external PWM inputs. Fully synchronous to one clock.

Parameters:
W, 16, width of the high-time/period counters and outputs; minimum 2
FILT_LEN, 3, glitch-filter stability length in cycles; used only when PWM_MEAS_FILT_EN is defined; minimum 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pwm_in  input  1  PWM waveform; asynchronous to clk
clr  input  1  synchronous clear of state, outputs and flags
high_time  output  W  high cycles of the last complete period
period  output  W  total cycles of the last complete period, rising edge to rising edge
valid  output  1  one-cycle pulse when high_time/period are updated
timeout  output  1  sticky; no edge seen for 2^W-1 cycles
level  output  1  current synchronized (filtered) input level

Behaviour:
- Reset (rst_n=0, async): high_time=0, period=0, valid=0, timeout=0, level=0, sync flops=0, state=IDLE, internal counters=0.
- Input path: 2-flop synchronizer -> s. One delay flop d. rise = s & ~d; fall = ~s & d. level = s.
- Latency: pwm_in rising and stable before clk edge k -> rise is combinationally true between edges k+1 and k+2 -> valid=1 for the cycle after edge k+2.
- FSM states IDLE, HIGH, LOW:
  - IDLE: wait for rise. On rise: cnt_hi<=1, cnt_per<=1, -> HIGH. A fall in IDLE is ignored. No publish from IDLE.
  - HIGH: each cycle cnt_per++; if s=1 also cnt_hi++. On fall: cnt_per++, -> LOW.
  - LOW: each cycle cnt_per++. On rise: high_time<=cnt_hi, period<=cnt_per, valid<=1, cnt_hi<=1, cnt_per<=1, -> HIGH.
- First valid occurs only at the second observed rising edge; the first partial period is discarded.
- valid is a single-cycle pulse; deasserts on the next edge unless another publish occurs.
- Timeout: if cnt_per reaches 2^W-1 in HIGH or LOW -> timeout<=1 (sticky), state->IDLE, counters cleared, high_time/period hold their last values, no valid. This covers 0% and 100% duty and periods too long for W.
- Arithmetic: unsigned W-bit. Counters never wrap, because timeout fires first.
- clr=1: state=IDLE, counters=0, high_time=0, period=0, valid=0, timeout=0. Sync flops and level are not cleared. clr has priority over a simultaneous rise, fall or timeout.
- Reset asserted mid-measurement: immediate return to reset values. After release, measurement restarts from IDLE.

Optional Feature:
PWM_MEAS_FILT_EN
- Defined: a glitch filter sits between the synchronizer output and s. The filtered level changes only after the raw synchronized input differs from it for FILT_LEN consecutive cycles. Pulses shorter than FILT_LEN cycles are ignored. Adds FILT_LEN cycles of latency to rise, fall and valid. Reset value of the filtered level is 0. clr does not affect the filter.
- Not defined: s is the synchronizer output directly. FILT_LEN is unused.

Decomposition:
- pwm_meas_pkg:
  - typedef enum logic [1:0] meas_state_t {IDLE, HIGH, LOW}
  - localparam default width 16
  - localparam default filter length 3
- Sub-module pwm_sync_edge: contains the 2-flop synchronizer, the optional filter, the delay flop, and rise/fall/level outputs. It has clk and rst_n, but no clr.
- pwm_meas holds the FSM, counters and output registers.

Test Plan:
- Stimulus: pwm_in 3 high / 5 low cycles, repeated 4 periods. Response: valid pulses 3 times (first at the 2nd rise); high_time=3, period=8 each; valid asserts the cycle after the 3rd clk edge following pwm_in rise; timeout=0.
- Stimulus: pwm_in held 1 after one rise, W=4. Response: timeout=1 after cnt_per reaches 15, no valid, state IDLE; later 2/2 waveform: first valid after the second rise reports high_time=2, period=4, and timeout stays 1.
- Stimulus: clr pulsed in the same cycle as a rise ending a 4/4 period. Response: no valid; high_time=0, period=0; next full period then reports 4/8.
- Stimulus: rst_n low for 1 cycle mid-HIGH. Response: all outputs 0 immediately, asynchronously; measurement resumes, with the first valid at the 2nd rise after release.
- Stimulus: duty change 2/6 -> 6/2 on a period boundary. Response: reports 2/8, then 6/8 on the following valid, with no intermediate value.
- Stimulus (PWM_MEAS_FILT_EN, FILT_LEN=3): 1-cycle and 2-cycle high glitches on a low line, then 5/5 waveform. Response: glitches produce no rise; level stays 0; valid reports high_time=5, period=10 with 3 extra cycles of latency.
